// File: rtl/vram_arbiter_if.sv
// Pipelined Wishbone bundle shared by the display fetch master, the CPU window
// and the video memory port of the arbiter.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic        stall;

    modport master (
        output cyc, stb, we, adr, sel, wdat,
        input  rdat, ack, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, wdat,
        output rdat, ack, stall
    );
endinterface

// File: rtl/vram_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter for video memory: display
// fetch has fixed priority, a CPU wait counter bounds how long the CPU starves.
module vram_arbiter #(
    parameter int OUTSTANDING_MAX = 4,
    parameter int CPU_WAIT_MAX    = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    if_wb.slave        vid_bus,
    if_wb.slave        cpu_bus,
    if_wb.master       mem_bus,
    output logic [1:0] grant_o
);

    localparam int OW = $clog2(OUTSTANDING_MAX + 1);
    localparam int WW = $clog2(CPU_WAIT_MAX + 1);

    localparam logic [OW-1:0] OUT_MAX  = OW'(OUTSTANDING_MAX);
    localparam logic [WW-1:0] WAIT_MAX = WW'(CPU_WAIT_MAX);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_VID  = 2'd1;
    localparam logic [1:0] ST_CPU  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [WW-1:0] cpu_wait_q, cpu_wait_d;
    logic [1:0]    grant_q, grant_d;

    logic        own_cyc, own_stb, own_we;
    logic [31:0] own_adr, own_wdat;
    logic [3:0]  own_sel;
    logic        is_vid, is_cpu;
    logic        at_cap, starve;
    logic        mem_stb, accept, ack_seen;

    assign is_vid   = (state_q == ST_VID);
    assign is_cpu   = (state_q == ST_CPU);
    assign at_cap   = (outstanding_q == OUT_MAX);
    assign starve   = (cpu_wait_q == WAIT_MAX);

    // Owner select: in IDLE (or any unused encoding) nothing reaches memory.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_adr  = '0;
        own_sel  = '0;
        own_wdat = '0;
        case (state_q)
            ST_VID: begin
                own_cyc  = vid_bus.cyc;
                own_stb  = vid_bus.stb;
                own_we   = vid_bus.we;
                own_adr  = vid_bus.adr;
                own_sel  = vid_bus.sel;
                own_wdat = vid_bus.wdat;
            end
            ST_CPU: begin
                own_cyc  = cpu_bus.cyc;
                own_stb  = cpu_bus.stb;
                own_we   = cpu_bus.we;
                own_adr  = cpu_bus.adr;
                own_sel  = cpu_bus.sel;
                own_wdat = cpu_bus.wdat;
            end
            default: ;
        endcase
    end

    assign mem_stb  = own_stb & ~at_cap;
    assign accept   = mem_stb & ~mem_bus.stall;
    assign ack_seen = (is_vid | is_cpu) & mem_bus.ack;

    assign mem_bus.cyc  = own_cyc;
    assign mem_bus.stb  = mem_stb;
    assign mem_bus.we   = own_we;
    assign mem_bus.adr  = own_adr;
    assign mem_bus.sel  = own_sel;
    assign mem_bus.wdat = own_wdat;

    // Non-owners see a permanently stalled, silent slave.
    assign vid_bus.stall = is_vid ? (mem_bus.stall | at_cap) : 1'b1;
    assign vid_bus.ack   = is_vid & mem_bus.ack;
    assign vid_bus.rdat  = is_vid ? mem_bus.rdat : 32'h0;
    assign cpu_bus.stall = is_cpu ? (mem_bus.stall | at_cap) : 1'b1;
    assign cpu_bus.ack   = is_cpu & mem_bus.ack;
    assign cpu_bus.rdat  = is_cpu ? mem_bus.rdat : 32'h0;

    assign grant_o = grant_q;

    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_bus.cyc && starve) begin
                    state_d = ST_CPU;
                end else if (vid_bus.cyc) begin
                    state_d = ST_VID;
                end else if (cpu_bus.cyc) begin
                    state_d = ST_CPU;
                end
            end
            ST_VID, ST_CPU: begin
                // Dropping cyc ends the grant; anything still in flight is abandoned.
                if (!own_cyc) begin
                    state_d       = ST_IDLE;
                    outstanding_d = '0;
                end else if (accept && !ack_seen) begin
                    outstanding_d = outstanding_q + OW'(1);
                end else if (!accept && ack_seen && (outstanding_q != '0)) begin
                    outstanding_d = outstanding_q - OW'(1);
                end
            end
            default: begin
                state_d       = ST_IDLE;
                outstanding_d = '0;
            end
        endcase
    end

    always_comb begin
        cpu_wait_d = cpu_wait_q;
        if (!cpu_bus.cyc) begin
            cpu_wait_d = '0;
        end else if (!is_cpu && (state_d == ST_CPU)) begin
            cpu_wait_d = '0;
        end else if (!is_cpu && !starve) begin
            cpu_wait_d = cpu_wait_q + WW'(1);
        end
    end

    always_comb begin
        case (state_d)
            ST_VID:  grant_d = 2'b01;
            ST_CPU:  grant_d = 2'b10;
            default: grant_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            outstanding_q <= '0;
            cpu_wait_q    <= '0;
            grant_q       <= 2'b00;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            cpu_wait_q    <= cpu_wait_d;
            grant_q       <= grant_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a directed vector table, hand-written
// corner sequences and randomized traffic checked against a queue-based model.
module tb_vram_arbiter;

    localparam int OMAX = 4;
    localparam int WMAX = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] grant;

    if_wb vid_if ();
    if_wb cpu_if ();
    if_wb mem_if ();

    vram_arbiter #(
        .OUTSTANDING_MAX(OMAX),
        .CPU_WAIT_MAX   (WMAX)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .vid_bus(vid_if),
        .cpu_bus(cpu_if),
        .mem_bus(mem_if),
        .grant_o(grant)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who owns the port, which request addresses are in flight, how long the CPU waited.
    int          m_owner;
    int          m_wait;
    logic [31:0] m_pend[$];

    typedef struct {
        logic        vc, vs, cc, cs, ms, ma;
        logic [31:0] rd;
        logic [1:0]  eg;
        logic        emc, ems, evst, evack, ecst, ecack;
        logic [31:0] evd, ecd;
    } vec_t;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic set_idle();
        vid_if.cyc = 0; vid_if.stb = 0; vid_if.we = 0; vid_if.adr = 32'h200; vid_if.sel = 4'hF; vid_if.wdat = 0;
        cpu_if.cyc = 0; cpu_if.stb = 0; cpu_if.we = 1; cpu_if.adr = 32'h100; cpu_if.sel = 4'hF;
        cpu_if.wdat = 32'hDEADBEEF;
        mem_if.ack = 0; mem_if.stall = 0; mem_if.rdat = 32'h0BADF00D;
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_wait  = 0;
        m_pend.delete();
    endtask

    function automatic logic [71:0] observed();
        return {grant, mem_if.cyc, mem_if.stb, vid_if.stall, vid_if.ack, cpu_if.stall, cpu_if.ack,
                vid_if.rdat, cpu_if.rdat};
    endfunction

    function automatic logic [71:0] model_out();
        logic        cap, mc, ms, vs, va, cs, ca;
        logic [1:0]  g;
        logic [31:0] vd, cd;
        cap = (m_pend.size() == OMAX);
        g   = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        mc  = (m_owner == 1) ? vid_if.cyc : (m_owner == 2) ? cpu_if.cyc : 1'b0;
        ms  = ((m_owner == 1) ? vid_if.stb : (m_owner == 2) ? cpu_if.stb : 1'b0) && !cap;
        vs  = (m_owner == 1) ? (mem_if.stall || cap) : 1'b1;
        va  = (m_owner == 1) ? mem_if.ack : 1'b0;
        vd  = (m_owner == 1) ? mem_if.rdat : 32'h0;
        cs  = (m_owner == 2) ? (mem_if.stall || cap) : 1'b1;
        ca  = (m_owner == 2) ? mem_if.ack : 1'b0;
        cd  = (m_owner == 2) ? mem_if.rdat : 32'h0;
        return {g, mc, ms, vs, va, cs, ca, vd, cd};
    endfunction

    function automatic logic [68:0] owner_fields(input int who);
        if (who == 1) return {vid_if.adr, vid_if.we, vid_if.sel, vid_if.wdat};
        return {cpu_if.adr, cpu_if.we, cpu_if.sel, cpu_if.wdat};
    endfunction

    task automatic model_advance();
        int   old;
        logic oc, os, acc;
        old = m_owner;
        if (m_owner != 0) begin
            oc = (m_owner == 1) ? vid_if.cyc : cpu_if.cyc;
            os = (m_owner == 1) ? vid_if.stb : cpu_if.stb;
            if (!oc) begin
                m_owner = 0;
                m_pend.delete();
            end else begin
                acc = os && (m_pend.size() < OMAX) && !mem_if.stall;
                if (acc && mem_if.ack) begin
                    // one request in, one out: in-flight count unchanged
                end else if (acc) begin
                    m_pend.push_back((m_owner == 1) ? vid_if.adr : cpu_if.adr);
                end else if (mem_if.ack && m_pend.size() > 0) begin
                    void'(m_pend.pop_front());
                end
            end
        end else begin
            if (cpu_if.cyc && m_wait == WMAX) m_owner = 2;
            else if (vid_if.cyc)              m_owner = 1;
            else if (cpu_if.cyc)              m_owner = 2;
        end
        if (!cpu_if.cyc)                      m_wait = 0;
        else if (old == 0 && m_owner == 2)    m_wait = 0;
        else if (old != 2 && m_wait < WMAX)   m_wait++;
    endtask

    // Called just after a falling edge once inputs are set; compares before the rising edge.
    task automatic step(input string name);
        #2;
        check(name, observed(), model_out());
        if (m_owner != 0)
            check({name, "_fwd"}, {mem_if.adr, mem_if.we, mem_if.sel, mem_if.wdat}, owner_fields(m_owner));
        model_advance();
    endtask

    initial begin
        vec_t tbl[15];
        int   n_acc, issued, v_acc, v_ack;
        logic saw_cpu;
        logic [31:0] d;

        d = 32'h0BADF00D;
        //           vc vs cc cs ms ma rd            eg     mc ms vst vak cst cak vd  cd
        tbl[0]  = '{0, 0, 0, 0, 0, 0, d,            2'b00, 0, 0, 1, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 1, 0, 0, d,            2'b00, 0, 0, 1, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 1, 0, 0, d,            2'b10, 1, 1, 1, 0, 0, 0, 0, d};
        tbl[3]  = '{0, 0, 1, 0, 0, 1, d,            2'b10, 1, 0, 1, 0, 0, 1, 0, d};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, d,            2'b10, 0, 0, 1, 0, 0, 0, 0, d};
        tbl[5]  = '{1, 0, 1, 0, 0, 0, d,            2'b00, 0, 0, 1, 0, 1, 0, 0, 0};
        tbl[6]  = '{1, 1, 1, 1, 0, 0, d,            2'b01, 1, 1, 0, 0, 1, 0, d, 0};
        tbl[7]  = '{1, 0, 1, 0, 0, 1, d,            2'b01, 1, 0, 0, 1, 1, 0, d, 0};
        tbl[8]  = '{0, 0, 1, 0, 0, 0, d,            2'b01, 0, 0, 0, 0, 1, 0, d, 0};
        tbl[9]  = '{0, 0, 1, 1, 0, 0, d,            2'b00, 0, 0, 1, 0, 1, 0, 0, 0};
        tbl[10] = '{0, 0, 1, 1, 1, 0, d,            2'b10, 1, 1, 1, 0, 1, 0, 0, d};
        tbl[11] = '{0, 0, 1, 1, 0, 0, d,            2'b10, 1, 1, 1, 0, 0, 0, 0, d};
        tbl[12] = '{0, 0, 1, 0, 0, 1, 32'h12345678, 2'b10, 1, 0, 1, 0, 0, 1, 0, 32'h12345678};
        tbl[13] = '{0, 0, 0, 0, 0, 0, d,            2'b10, 0, 0, 1, 0, 0, 0, 0, d};
        tbl[14] = '{0, 0, 0, 0, 0, 0, d,            2'b00, 0, 0, 1, 0, 1, 0, 0, 0};

        set_idle();
        model_reset();
        #1 rst_n = 0;
        mem_if.ack = 1;
        #3;
        check("reset_state", observed(), {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0});
        mem_if.ack = 0;
        #11 rst_n = 1;

        // Directed vector table: single CPU write, contention, CPU read routing.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            vid_if.cyc = tbl[i].vc; vid_if.stb = tbl[i].vs;
            cpu_if.cyc = tbl[i].cc; cpu_if.stb = tbl[i].cs;
            mem_if.stall = tbl[i].ms; mem_if.ack = tbl[i].ma; mem_if.rdat = tbl[i].rd;
            #2;
            check($sformatf("table_row%0d", i), observed(),
                  {tbl[i].eg, tbl[i].emc, tbl[i].ems, tbl[i].evst, tbl[i].evack, tbl[i].ecst, tbl[i].ecack,
                   tbl[i].evd, tbl[i].ecd});
            if (tbl[i].eg == 2'b10)
                check($sformatf("table_fwd%0d", i), {mem_if.adr, mem_if.we, mem_if.sel, mem_if.wdat},
                      {32'h100, 1'b1, 4'hF, 32'hDEADBEEF});
            else if (tbl[i].eg == 2'b01)
                check($sformatf("table_fwd%0d", i), {mem_if.adr, mem_if.we, mem_if.sel, mem_if.wdat},
                      {32'h200, 1'b0, 4'hF, 32'h0});
            model_advance();
            $display("table row %0d grant=%b", i, grant);
        end

        // Outstanding cap: six back-to-back requests, acks held off.
        n_acc = 0; issued = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            set_idle();
            vid_if.cyc = 1; vid_if.stb = (issued < 6); vid_if.adr = 32'h1000 + 32'(issued * 4);
            step("cap_fill");
            if (mem_if.stb && !mem_if.stall) n_acc++;
            if (vid_if.stb && !vid_if.stall) issued++;
            if (c == 11) check("cap_stall_held", vid_if.stall, 1'b1);
        end
        check("cap_accepted", n_acc, 4);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            set_idle();
            vid_if.cyc = 1; vid_if.stb = (issued < 6); vid_if.adr = 32'h1000 + 32'(issued * 4);
            mem_if.ack = (m_pend.size() > 0);
            step("cap_drain");
            if (mem_if.stb && !mem_if.stall) n_acc++;
            if (vid_if.stb && !vid_if.stall) issued++;
        end
        check("cap_total", n_acc, 6);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); set_idle(); step("cap_release");
        end
        $display("sequence cap: accepted %0d", n_acc);

        // Starvation: video keeps re-requesting 3-beat bursts while the CPU waits.
        saw_cpu = 0; v_acc = 0; v_ack = 0;
        for (int c = 0; c < 100 && !saw_cpu; c++) begin
            @(negedge clk);
            set_idle();
            cpu_if.cyc = 1;
            if (v_acc >= 3 && v_ack >= 3) begin
                vid_if.cyc = 0; v_acc = 0; v_ack = 0;
            end else begin
                vid_if.cyc = 1; vid_if.stb = (v_acc < 3);
            end
            mem_if.ack = (m_pend.size() > 0);
            step("starve");
            if (vid_if.stb && !vid_if.stall) v_acc++;
            if (vid_if.ack) v_ack++;
            if (grant == 2'b10) saw_cpu = 1;
        end
        check("starve_cpu_granted", saw_cpu, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); set_idle(); step("starve_release");
        end
        $display("sequence starve: cpu granted=%0b", saw_cpu);

        // Abort with two requests in flight, late acks, then a clean CPU access.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); set_idle(); vid_if.cyc = 1; vid_if.stb = (c > 0); step("abort_issue");
        end
        @(negedge clk); set_idle(); step("abort_drop");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); set_idle(); mem_if.ack = 1; step("abort_late_ack");
            check("abort_idle", grant, 2'b00);
            check("abort_ack_blocked", {vid_if.ack, cpu_if.ack}, 2'b00);
        end
        @(negedge clk); set_idle(); cpu_if.cyc = 1; cpu_if.stb = 1; step("abort_cpu_req");
        @(negedge clk); set_idle(); cpu_if.cyc = 1; cpu_if.stb = 1; step("abort_cpu_stb");
        @(negedge clk); set_idle(); cpu_if.cyc = 1; mem_if.ack = 1; step("abort_cpu_ack");
        check("abort_cpu_done", cpu_if.ack, 1'b1);
        @(negedge clk); set_idle(); step("abort_cpu_rel");
        @(negedge clk); set_idle(); step("abort_idle2");
        $display("sequence abort: done");

        // Asynchronous reset pulse in the middle of a CPU burst.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); set_idle(); cpu_if.cyc = 1; cpu_if.stb = 1; step("rst_burst");
        end
        @(negedge clk);
        set_idle(); cpu_if.cyc = 1; cpu_if.stb = 1; mem_if.ack = 1; mem_if.rdat = 32'hFFFF0000;
        #1 rst_n = 0;
        #1;
        check("rst_async_outputs", observed(), {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0});
        cpu_if.cyc = 0; cpu_if.stb = 0;
        #2 rst_n = 1;
        model_reset();
        step("rst_release");
        @(negedge clk); set_idle(); mem_if.ack = 1; step("rst_late_ack");
        @(negedge clk); set_idle(); vid_if.cyc = 1; vid_if.stb = 1; step("rst_vid_req");
        @(negedge clk); set_idle(); vid_if.cyc = 1; vid_if.stb = 1; step("rst_vid_stb");
        @(negedge clk); set_idle(); vid_if.cyc = 1; mem_if.ack = 1; mem_if.rdat = 32'hCAFE0001; step("rst_vid_ack");
        check("rst_vid_done", {vid_if.ack, vid_if.rdat}, {1'b1, 32'hCAFE0001});
        @(negedge clk); set_idle(); step("rst_vid_rel");
        $display("sequence reset: done");

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!vid_if.cyc) vid_if.cyc = ($urandom_range(3) == 0);
            else if ($urandom_range(7) == 0) vid_if.cyc = 0;
            if (!cpu_if.cyc) cpu_if.cyc = ($urandom_range(3) == 0);
            else if ($urandom_range(9) == 0) cpu_if.cyc = 0;
            vid_if.stb  = vid_if.cyc && ($urandom_range(1) == 1);
            cpu_if.stb  = cpu_if.cyc && ($urandom_range(1) == 1);
            vid_if.adr  = $urandom; vid_if.wdat = $urandom; vid_if.we = 1'($urandom_range(1));
            vid_if.sel  = 4'($urandom_range(15));
            cpu_if.adr  = $urandom; cpu_if.wdat = $urandom; cpu_if.we = 1'($urandom_range(1));
            cpu_if.sel  = 4'($urandom_range(15));
            mem_if.stall = ($urandom_range(3) == 0);
            mem_if.ack   = (m_pend.size() > 0) ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            mem_if.rdat  = $urandom;
            step("random");
        end
        $display("sequence random: 3000 cycles");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Two-master to one-slave Wishbone arbiter in front of video memory. The text-mode VGA display engine's fetch master and the CPU's video-RAM window share one memory port. Display fetch has fixed priority so scanlines are never starved. A wait counter guarantees the CPU a grant within a bounded time. Pipelined Wishbone throughout, with a per-grant cap on outstanding requests.

## Interface
Parameters:
- OUTSTANDING_MAX, 4: maximum accepted-but-unacked requests on mem_bus during one grant (≥1).
- CPU_WAIT_MAX, 64: cycles a requesting, ungranted CPU waits before it takes priority over video at the next arbitration (≥1).

Ports:
- clk_i  in  1  sole clock; all logic synchronous to it.
- rst_ni  in  1  asynchronous, active-low reset.
- vid_bus  if_wb.slave  32-bit data/adr, 4-bit sel  display fetch master (highest priority).
- cpu_bus  if_wb.slave  32-bit data/adr, 4-bit sel  CPU video-RAM window.
- mem_bus  if_wb.master  32-bit data/adr, 4-bit sel  video memory.
- grant_o  out  2  current owner: 2'b01 video, 2'b10 CPU, 2'b00 none.

## Operation
- State machine with three states: IDLE, VID, CPU.
- Transitions out of IDLE, evaluated in priority order:
  - cpu_bus.cyc & starve → CPU.
  - vid_bus.cyc → VID.
  - cpu_bus.cyc → CPU.
  - otherwise stay in IDLE.
- VID/CPU → IDLE when the owner drops cyc and outstanding == 0.
  - Also when cyc drops with outstanding > 0 (abort); outstanding is cleared to 0.
  - There is no direct VID↔CPU transition; every handover passes through IDLE for one cycle.
- Behaviour while granted:
  - Owner's cyc, stb, we, adr, sel and dat are driven combinationally onto mem_bus.
  - mem_bus.ack and mem_bus.dat are returned to the owner.
  - Owner's stall = mem_bus.stall | (outstanding == OUTSTANDING_MAX).
  - mem_bus.stb = owner stb & (outstanding != OUTSTANDING_MAX).
- Non-owner, and both masters in IDLE: stall = 1, ack = 0, dat = 32'h0. mem_bus.cyc = stb = 0 in IDLE.
- outstanding counter, width $clog2(OUTSTANDING_MAX+1):
  - +1 on an accepted request (mem stb & ~mem stall).
  - −1 on mem ack.
  - Accept and ack in the same cycle: unchanged.
  - Never exceeds OUTSTANDING_MAX. An ack arriving at 0 is ignored (no underflow).
- Acks arriving in IDLE (late acks after an abort) are discarded and not routed to any master.
- cpu_wait counter:
  - Increments each cycle cpu_bus.cyc is high and state != CPU; saturates at CPU_WAIT_MAX.
  - starve = (cpu_wait == CPU_WAIT_MAX).
  - Cleared to 0 on entry to CPU and whenever cpu_bus.cyc is low.
- grant_o is a registered decode of the state.

## Timing
- Reset (rst_ni low, asynchronous):
  - state = IDLE, outstanding = 0, cpu_wait = 0, grant_o = 2'b00.
  - mem_bus.cyc = stb = 0.
  - Both slaves: stall = 1, ack = 0, dat = 0.
- Reset asserted mid-transaction abandons it; any ack after reset release is discarded.
- Request-to-grant latency: cyc rising in cycle N with the arbiter in IDLE gives the grant in N+1. The first stb can be accepted in N+1.
- Once granted, forwarding adds zero latency: mem ack in cycle M is seen by the owner in cycle M.
- Release latency: cyc low with outstanding == 0 in cycle N gives IDLE in N+1; the next grant lands in N+2.
- Simultaneous cyc from both masters in IDLE: video wins unless starve is set.
- Worst-case CPU wait is CPU_WAIT_MAX cycles, plus the remaining video grant, plus 2 cycles.

## Test plan
- Single master: CPU writes 32'hDEADBEEF at adr 0x100, sel 4'hF. Grant follows cyc by 1 cycle; mem_bus sees the write; ack returns to the CPU the same cycle as mem ack; video sees stall = 1.
- Contention: vid and cpu raise cyc in the same IDLE cycle. grant_o = 01. CPU is granted 2 cycles after vid drops cyc with nothing outstanding; CPU read data 32'h12345678 is routed only to the CPU.
- Outstanding cap: video issues 6 back-to-back stb with mem ack delayed by 10 cycles and OUTSTANDING_MAX = 4. Exactly 4 are accepted, then the owner stall stays high until the first ack; the counter never exceeds 4.
- Starvation: with CPU_WAIT_MAX = 8, hold vid in repeated 3-request bursts while cpu.cyc stays high. After starve is set, the next IDLE grants the CPU even though vid.cyc is high.
- Abort: video drops cyc with 2 requests outstanding. The arbiter goes to IDLE next cycle with outstanding = 0; the two late acks reach neither master; a following CPU access completes normally.
- Async reset mid-burst: pulse rst_ni low between clock edges during a CPU burst. All outputs take their reset values immediately; after release, a new video access succeeds.
